// File: rtl/i2s_master_scheduler.sv
// I2S clock master and capture sequencer.
// Generates the codec bit clock and word select from clk, counts stereo frames
// into analysis windows, and runs a done/ack handshake with an overrun flag.
// Start and stop requests only take effect on frame boundaries, so the codec
// never sees a partial frame.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   enable        level request to run the codec clocks
//   windowAck     one-cycle pulse from the consumer, clears windowDone
//   codecBitClock generated bit clock (registered)
//   codecLRClock  generated word select, 0 = left, 1 = right (registered)
//   running       high while in RUN or STOP
//   frameStrobe   one-cycle pulse at the end of each complete stereo frame
//   frameCount    frames completed in the current window
//   windowDone    window complete, awaiting windowAck
//   overrun       sticky, a window completed while windowDone was still set
module i2s_master_scheduler #(
  parameter int unsigned CLK_DIV          = 4,
  parameter int unsigned BITS_PER_CHANNEL = 32,
  parameter int unsigned WINDOW_FRAMES    = 256,
  parameter int unsigned CNT_W            = $clog2(WINDOW_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             windowAck,
  output logic             codecBitClock,
  output logic             codecLRClock,
  output logic             running,
  output logic             frameStrobe,
  output logic [CNT_W-1:0] frameCount,
  output logic             windowDone,
  output logic             overrun
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (BITS_PER_CHANNEL > 1) ? $clog2(2 * BITS_PER_CHANNEL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               bclk_d, lr_d, fs_d, wd_d, ov_d, running_d;
  logic [CNT_W-1:0]   fc_d;
  logic               div_wrap_c, fall_c, frame_end_c;

  // Next-state, divider, bit counter and window bookkeeping.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    bclk_d      = codecBitClock;
    lr_d        = codecLRClock;
    fc_d        = frameCount;
    wd_d        = windowDone;
    ov_d        = overrun;
    fs_d        = 1'b0;
    frame_end_c = 1'b0;
    div_wrap_c  = (div_q == DIV_W'(CLK_DIV - 1));
    fall_c      = (state_q != IDLE) && div_wrap_c && codecBitClock;

    if (state_q != IDLE) begin
      if (div_wrap_c) begin
        div_d  = '0;
        bclk_d = ~codecBitClock;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (fall_c) begin
        if (bit_q == BIT_W'(2 * BITS_PER_CHANNEL - 1)) begin
          bit_d       = '0;
          lr_d        = 1'b0;
          frame_end_c = 1'b1;
        end else begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(BITS_PER_CHANNEL - 1)) lr_d = 1'b1;
        end
      end
    end
    fs_d = frame_end_c;

    // Window counting follows the visible strobe so the consumer's ack and
    // the strobe it reacts to live in the same cycle.
    if (frameStrobe) begin
      if (frameCount == CNT_W'(WINDOW_FRAMES - 1)) begin
        fc_d = '0;
        wd_d = 1'b1;
        if (windowDone && !windowAck) ov_d = 1'b1;
      end else begin
        fc_d = frameCount + CNT_W'(1);
        if (windowAck) wd_d = 1'b0;
      end
    end else if (windowAck) begin
      wd_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          div_d   = '0;
          bit_d   = '0;
          fc_d    = '0;
          ov_d    = 1'b0;
        end
      end
      RUN: begin
        if (!enable) state_d = STOP;
      end
      STOP: begin
        if (enable) begin
          state_d = RUN;
        end else if (frame_end_c) begin
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
          bclk_d  = 1'b0;
          lr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lr_d    = 1'b0;
      end
    endcase

    running_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bit_q         <= '0;
      codecBitClock <= 1'b0;
      codecLRClock  <= 1'b0;
      running       <= 1'b0;
      frameStrobe   <= 1'b0;
      frameCount    <= '0;
      windowDone    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      codecBitClock <= bclk_d;
      codecLRClock  <= lr_d;
      running       <= running_d;
      frameStrobe   <= fs_d;
      frameCount    <= fc_d;
      windowDone    <= wd_d;
      overrun       <= ov_d;
    end
  end

endmodule
